// File: rtl/ctrl_sequencer_pkg.sv
// ctrl_sequencer_pkg
//   Shared definitions for the instruction fetch/decode control unit:
//   ALU opcode mnemonics, controller state encoding, instruction field
//   positions and small opcode classification helpers.
package ctrl_sequencer_pkg;

   typedef enum logic [3:0] {
      OP_ADD    = 4'h0,
      OP_SUB    = 4'h1,
      OP_BEQ    = 4'h2,
      OP_SL     = 4'h3,
      OP_SR     = 4'h4,
      OP_LW     = 4'h5,
      OP_SW     = 4'h6,
      OP_MOV    = 4'h7,
      OP_ASSIGN = 4'h8,
      OP_BGE    = 4'h9,
      OP_BNE    = 4'hA,
      OP_AND    = 4'hB,
      OP_OR     = 4'hC,
      OP_HALT   = 4'hF
   } op_mne;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_DONE  = 3'd4
   } ctrl_state_t;

   // Instruction layout: [8:5] opcode, [4] mode (1 = reg, 0 = imm), [3:0] index/imm
   localparam int OPC_HI   = 8;
   localparam int OPC_LO   = 5;
   localparam int MODE_BIT = 4;
   localparam int FLD_HI   = 3;
   localparam int FLD_LO   = 0;

   // Conditional skips: pc+2 when the ALU reports the condition true
   function automatic logic is_branch(input logic [3:0] op);
      return (op == OP_BEQ) || (op == OP_BGE) || (op == OP_BNE);
   endfunction

   // Ops whose ALU shift/carry out is kept for the next instruction
   function automatic logic is_carry_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SL) || (op == OP_SR);
   endfunction

   // Ops that write the accumulator during EXEC (LW writes it later, in MEM)
   function automatic logic writes_acc(input logic [3:0] op, input logic mode);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SL) || (op == OP_SR) ||
             (op == OP_AND) || (op == OP_OR)  || (op == OP_ASSIGN) ||
             ((op == OP_MOV) && mode);
   endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if
//   ALU control interface between the sequencer (master, issuing end) and
//   the ALU (slave).
//   master drives : alu_op, reg_exe, imm_exe, reg_to_acc, acc_to_reg,
//                   imm_out, rf_addr, sc_in
//   master samples: alu_sc_out (ALU shift/carry out), branch_en (1 = skip)
interface ctrl_sequencer_if;
   logic [3:0] alu_op;
   logic       reg_exe;
   logic       imm_exe;
   logic       reg_to_acc;
   logic       acc_to_reg;
   logic [7:0] imm_out;
   logic [3:0] rf_addr;
   logic       sc_in;
   logic       alu_sc_out;
   logic       branch_en;

   modport master (
      output alu_op, reg_exe, imm_exe, reg_to_acc, acc_to_reg, imm_out, rf_addr, sc_in,
      input  alu_sc_out, branch_en
   );

   modport slave (
      input  alu_op, reg_exe, imm_exe, reg_to_acc, acc_to_reg, imm_out, rf_addr, sc_in,
      output alu_sc_out, branch_en
   );
endinterface

// File: rtl/ctrl_sequencer_prog_counter.sv
// prog_counter
//   Program counter register. Clear has priority, then +2, then +1,
//   otherwise hold. Wraps modulo 2**PC_W.
//   Ports: CLK, Reset_n (async, active low), clr, inc1, inc2 in; pc out.
module prog_counter #(
   parameter int PC_W = 8
) (
   input  logic            CLK,
   input  logic            Reset_n,
   input  logic            clr,
   input  logic            inc1,
   input  logic            inc2,
   output logic [PC_W-1:0] pc
);

   logic [PC_W-1:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (clr)       pc_d = '0;
      else if (inc2) pc_d = pc_q + PC_W'(2);
      else if (inc1) pc_d = pc_q + PC_W'(1);
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) pc_q <= '0;
      else          pc_q <= pc_d;
   end

   assign pc = pc_q;

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
//   Instruction fetch/decode control unit. Fetches instructions from a
//   synchronous ROM, decodes them into ALU controls and datapath strobes,
//   and sequences the PC (fall through +1 or conditional skip +2).
//   Ports:
//     CLK, Reset_n      clock, async active-low reset
//     start / done     run control (start from PC 0 in IDLE/DONE; done after HALT)
//     prog_addr/instr  ROM address (= PC) and ROM data (valid one cycle later)
//     alu              ctrl_sequencer_if.master, ALU control interface
//     acc_we, rf_we    accumulator / register-file write strobes
//     mem_rd, mem_wr   data memory strobes
//   Build option: define CARRY_CHAIN_EN to keep the ALU carry-out of
//   ADD/SUB/SL/SR in a flop that feeds sc_in; otherwise sc_in is tied 0.
module ctrl_sequencer
   import ctrl_sequencer_pkg::*;
#(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 9
) (
   input  logic               CLK,
   input  logic               Reset_n,
   input  logic               start,
   output logic               done,
   output logic [PC_W-1:0]    prog_addr,
   input  logic [INSTR_W-1:0] instr,
   ctrl_sequencer_if.master   alu,
   output logic               acc_we,
   output logic               rf_we,
   output logic               mem_rd,
   output logic               mem_wr
);

   localparam logic [2:0] ST_IDLE  = S_IDLE;
   localparam logic [2:0] ST_FETCH = S_FETCH;
   localparam logic [2:0] ST_EXEC  = S_EXEC;
   localparam logic [2:0] ST_MEM   = S_MEM;
   localparam logic [2:0] ST_DONE  = S_DONE;

   logic [2:0] state_q, state_d;
   logic       pc_clr, pc_inc1, pc_inc2, carry_ld;
   logic       in_exec;

   logic [3:0] opc;
   logic       mode;
   logic [3:0] fld;

   assign opc  = instr[OPC_HI:OPC_LO];
   assign mode = instr[MODE_BIT];
   assign fld  = instr[FLD_HI:FLD_LO];

   // ---------------- sequencing ----------------
   always_comb begin
      state_d  = state_q;
      pc_clr   = 1'b0;
      pc_inc1  = 1'b0;
      pc_inc2  = 1'b0;
      carry_ld = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_FETCH;
               pc_clr  = 1'b1;
            end
         end
         ST_FETCH: state_d = ST_EXEC;
         ST_EXEC: begin
            carry_ld = is_carry_op(opc);
            if (opc == OP_HALT) begin
               state_d = ST_DONE;          // PC holds on HALT
            end else if (opc == OP_LW) begin
               state_d = ST_MEM;           // PC advances after the load completes
            end else begin
               state_d = ST_FETCH;
               if (is_branch(opc) && alu.branch_en) pc_inc2 = 1'b1;
               else                                 pc_inc1 = 1'b1;
            end
         end
         ST_MEM: begin
            state_d = ST_FETCH;
            pc_inc1 = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   prog_counter #(.PC_W(PC_W)) u_pc (
      .CLK     (CLK),
      .Reset_n (Reset_n),
      .clr     (pc_clr),
      .inc1    (pc_inc1),
      .inc2    (pc_inc2),
      .pc      (prog_addr)
   );

   // ---------------- decode ----------------
   // Controls are purely combinational from state and ROM data, so an
   // async reset removes any in-flight strobe in the same cycle.
   assign in_exec        = (state_q == ST_EXEC);
   assign done           = (state_q == ST_DONE);

   assign alu.alu_op     = in_exec ? opc : 4'h0;
   assign alu.reg_exe    = in_exec &  mode;
   assign alu.imm_exe    = in_exec & ~mode;
   assign alu.reg_to_acc = in_exec & (opc == OP_MOV) &  mode;
   assign alu.acc_to_reg = in_exec & (opc == OP_MOV) & ~mode;
   assign alu.imm_out    = in_exec ? {4'h0, fld} : 8'h00;
   assign alu.rf_addr    = in_exec ? fld : 4'h0;

   assign acc_we = (in_exec & writes_acc(opc, mode)) | (state_q == ST_MEM);
   assign rf_we  = in_exec & (opc == OP_MOV) & ~mode;
   assign mem_rd = in_exec & (opc == OP_LW);
   assign mem_wr = in_exec & (opc == OP_SW);

   // ---------------- carry chain ----------------
`ifdef CARRY_CHAIN_EN
   logic carry_q, carry_d;

   always_comb begin
      carry_d = carry_q;
      if (carry_ld) carry_d = alu.alu_sc_out;
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) carry_q <= 1'b0;
      else          carry_q <= carry_d;
   end

   assign alu.sc_in = carry_q;
`else
   logic unused_carry;
   assign unused_carry = alu.alu_sc_out | carry_ld;
   assign alu.sc_in    = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer
//   Self-checking bench for ctrl_sequencer: a decode vector table, hand
//   sequences for multi-cycle corners, and random programs compared against
//   an instruction-level trace model.
module tb_ctrl_sequencer;

`ifdef CARRY_CHAIN_EN
   localparam bit CARRY_ON = 1'b1;
`else
   localparam bit CARRY_ON = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       Reset_n;
   logic       start;
   logic       done;
   logic [7:0] prog_addr;
   logic [8:0] instr;
   logic       acc_we, rf_we, mem_rd, mem_wr;
   logic [8:0] rom [256];

   int checks = 0;
   int errors = 0;

   ctrl_sequencer_if alu_if ();

   ctrl_sequencer #(.PC_W(8), .INSTR_W(9)) dut (
      .CLK       (CLK),
      .Reset_n   (Reset_n),
      .start     (start),
      .done      (done),
      .prog_addr (prog_addr),
      .instr     (instr),
      .alu       (alu_if),
      .acc_we    (acc_we),
      .rf_we     (rf_we),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr)
   );

   always #5 CLK = ~CLK;

   // synchronous instruction ROM
   always @(posedge CLK) instr <= rom[prog_addr];

   typedef struct packed {
      logic       done;
      logic [7:0] addr;
      logic [3:0] op;
      logic       re, ie, r2a, a2r;
      logic [7:0] imm;
      logic [3:0] rfa;
      logic       sc, aw, rw, mr, mw;
   } outs_t;

   typedef struct {
      outs_t o;
      logic  br, sci, st;
   } step_t;

   step_t trace [$];

   // decode fields: {op[3:0], re ie r2a a2r aw rw mr mw, imm[7:0], rfa[3:0]}
   typedef struct {
      logic [8:0]  w;
      logic [23:0] exp;
   } dvec_t;

   localparam logic [8:0] NOP_W = 9'h1A0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic outs_t dut_outs();
      outs_t o;
      o.done = done;               o.addr = prog_addr;
      o.op   = alu_if.alu_op;      o.re   = alu_if.reg_exe;
      o.ie   = alu_if.imm_exe;     o.r2a  = alu_if.reg_to_acc;
      o.a2r  = alu_if.acc_to_reg;  o.imm  = alu_if.imm_out;
      o.rfa  = alu_if.rf_addr;     o.sc   = alu_if.sc_in;
      o.aw   = acc_we;             o.rw   = rf_we;
      o.mr   = mem_rd;             o.mw   = mem_wr;
      return o;
   endfunction

   function automatic logic [23:0] dut_dec();
      return {alu_if.alu_op, alu_if.reg_exe, alu_if.imm_exe, alu_if.reg_to_acc,
              alu_if.acc_to_reg, acc_we, rf_we, mem_rd, mem_wr,
              alu_if.imm_out, alu_if.rf_addr};
   endfunction

   function automatic outs_t quiet(input logic [7:0] pc, input logic c);
      outs_t o = '0;
      o.addr = pc;
      o.sc   = c;
      return o;
   endfunction

   task automatic fill_nop();
      for (int a = 0; a < 256; a++) rom[a] = NOP_W;
   endtask

   // ends at a falling edge with the controller in IDLE
   task automatic do_reset();
      start = 1'b0;
      alu_if.branch_en  = 1'b0;
      alu_if.alu_sc_out = 1'b0;
      Reset_n = 1'b0;
      repeat (2) @(negedge CLK);
      Reset_n = 1'b1;
   endtask

   // ends in cycle 1 (FETCH of PC 0)
   task automatic launch();
      do_reset();
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   // Instruction-level model: each instruction is a FETCH cycle, an EXEC
   // cycle and, for LW, a MEM cycle; the expected outputs of each cycle are
   // queued together with the inputs the bench will drive in that cycle.
   task automatic run_random(input int n_instr);
      logic [7:0] pc    = 8'h00;
      logic       carry = 1'b0;
      logic [8:0] w;
      logic [3:0] op;
      logic       m;
      step_t      s;
      for (int a = 0; a < 256; a++) rom[a] = {4'($urandom_range(0, 14)), 5'($urandom)};
      trace.delete();
      s.o = quiet(8'h00, 1'b0); s.br = 1'($urandom); s.sci = 1'($urandom); s.st = 1'b1;
      trace.push_back(s);
      for (int i = 0; i < n_instr; i++) begin
         w = rom[pc]; op = w[8:5]; m = w[4];
         s.o = quiet(pc, carry); s.br = 1'($urandom); s.sci = 1'($urandom); s.st = 1'($urandom);
         trace.push_back(s);
         s.o     = quiet(pc, carry);
         s.o.op  = op;
         s.o.re  = m;
         s.o.ie  = !m;
         s.o.r2a = (op == 4'd7) && m;
         s.o.a2r = (op == 4'd7) && !m;
         s.o.imm = {4'h0, w[3:0]};
         s.o.rfa = w[3:0];
         s.o.aw  = (op inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd8, 4'd11, 4'd12}) || ((op == 4'd7) && m);
         s.o.rw  = (op == 4'd7) && !m;
         s.o.mr  = (op == 4'd5);
         s.o.mw  = (op == 4'd6);
         s.br = 1'($urandom); s.sci = 1'($urandom); s.st = 1'($urandom);
         trace.push_back(s);
         if (CARRY_ON && (op inside {4'd0, 4'd1, 4'd3, 4'd4})) carry = s.sci;
         if ((op inside {4'd2, 4'd9, 4'd10}) && s.br) pc = pc + 8'd2;
         else                                         pc = pc + 8'd1;
         if (op == 4'd5) begin
            s.o = quiet(pc - 8'd1, carry); s.o.aw = 1'b1;
            s.br = 1'($urandom); s.sci = 1'($urandom); s.st = 1'($urandom);
            trace.push_back(s);
         end
      end
      do_reset();
      foreach (trace[k]) begin
         start = trace[k].st;
         alu_if.branch_en  = trace[k].br;
         alu_if.alu_sc_out = trace[k].sci;
         #1;
         chk($sformatf("rand_cyc%0d", k), 64'(dut_outs()), 64'(trace[k].o));
         @(negedge CLK);
      end
      start = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      dvec_t      dtab [10];
      logic [8:0] accv, donev;
      logic [3:0] op2, op4;
      logic       re4;

      dtab[0] = '{9'h105, 24'h8_48_05_5};  // ASSIGN #5
      dtab[1] = '{9'h013, 24'h0_88_03_3};  // ADD r3
      dtab[2] = '{9'h0F2, 24'h7_A8_02_2};  // MOV r2 -> acc
      dtab[3] = '{9'h0E2, 24'h7_54_02_2};  // MOV acc -> r2
      dtab[4] = '{9'h0D0, 24'h6_81_00_0};  // SW
      dtab[5] = '{9'h0B0, 24'h5_82_00_0};  // LW
      dtab[6] = '{9'h040, 24'h2_40_00_0};  // BEQ
      dtab[7] = '{9'h1A7, 24'hD_40_07_7};  // opcode 13 (NOP)
      dtab[8] = '{9'h16F, 24'hB_48_0F_F};  // AND #F
      dtab[9] = '{9'h099, 24'h4_88_09_9};  // SR r9

      start = 1'b0;
      alu_if.branch_en  = 1'b0;
      alu_if.alu_sc_out = 1'b0;
      Reset_n = 1'b0;
      fill_nop();
      #3;
      chk("reset_outputs", 64'(dut_outs()), 64'(quiet(8'h00, 1'b0)));

      // ---- decode table ----
      foreach (dtab[i]) begin
         fill_nop();
         rom[0] = dtab[i].w;
         launch();
         chk($sformatf("fetch_quiet_%0d", i), 64'(dut_outs()), 64'(quiet(8'h00, 1'b0)));
         @(negedge CLK);
         chk($sformatf("decode_%0d", i), 64'(dut_dec()), 64'(dtab[i].exp));
      end

      // ---- reset in the middle of an ADD's EXEC ----
      fill_nop();
      rom[1] = 9'h013;
      launch();
      repeat (3) @(negedge CLK);            // cycle 4: EXEC ADD at PC 1
      chk("rst_pre_acc_we", 64'(acc_we), 64'(1));
      chk("rst_pre_addr", 64'(prog_addr), 64'(1));
      #2 Reset_n = 1'b0;
      #1;
      chk("rst_acc_we", 64'(acc_we), 64'(0));
      chk("rst_outputs", 64'(dut_outs()), 64'(quiet(8'h00, 1'b0)));
      @(negedge CLK);
      Reset_n = 1'b1;
      repeat (3) @(negedge CLK);
      chk("rst_idle_hold", 64'(dut_outs()), 64'(quiet(8'h00, 1'b0)));

      // ---- ASSIGN 5, ADD r3, HALT ----
      fill_nop();
      rom[0] = 9'h105; rom[1] = 9'h013; rom[2] = 9'h1E0;
      do_reset();
      start = 1'b1;
      op2 = '0; op4 = '0; re4 = 1'b0;
      for (int c = 0; c < 9; c++) begin
         #1;
         accv[c]  = acc_we;
         donev[c] = done;
         if (c == 2) op2 = alu_if.alu_op;
         if (c == 4) begin op4 = alu_if.alu_op; re4 = alu_if.reg_exe; end
         @(negedge CLK);
         start = 1'b0;
      end
      chk("prog_acc_we_cycles", 64'(accv), 64'(9'b0_0001_0100));
      chk("prog_done_cycles", 64'(donev), 64'(9'b1_1000_0000));
      chk("prog_op_assign", 64'(op2), 64'(8));
      chk("prog_op_add", 64'(op4), 64'(0));
      chk("prog_reg_exe_add", 64'(re4), 64'(1));
      chk("prog_halt_pc", 64'(prog_addr), 64'(2));

      // ---- BEQ at PC 4, taken and not taken ----
      for (int t = 0; t < 2; t++) begin
         fill_nop();
         rom[4] = 9'h040;
         launch();
         repeat (9) @(negedge CLK);         // cycle 10: EXEC BEQ
         chk("beq_op", 64'(alu_if.alu_op), 64'(2));
         alu_if.branch_en = (t == 0);
         @(negedge CLK);
         alu_if.branch_en = 1'b0;
         chk(t == 0 ? "beq_taken_addr" : "beq_fall_addr", 64'(prog_addr), 64'(t == 0 ? 6 : 5));
      end

      // ---- LW at PC 2 ----
      fill_nop();
      rom[2] = 9'h0B0;
      launch();
      repeat (5) @(negedge CLK);            // cycle 6: EXEC LW
      chk("lw_exec_rd", 64'({mem_rd, acc_we}), 64'(2'b10));
      @(negedge CLK);
      chk("lw_mem_we", 64'({mem_rd, acc_we, prog_addr}), 64'({2'b01, 8'h02}));
      @(negedge CLK);
      chk("lw_next_fetch", 64'({acc_we, prog_addr}), 64'({1'b0, 8'h03}));

      // ---- PC wrap: BNE at 0xFE taken -> 0x00 ----
      fill_nop();
      rom[254] = 9'h140;
      launch();
      repeat (509) @(negedge CLK);          // cycle 510: EXEC at PC 0xFE
      chk("bne_op", 64'(alu_if.alu_op), 64'(10));
      alu_if.branch_en = 1'b1;
      @(negedge CLK);
      alu_if.branch_en = 1'b0;
      chk("wrap_fe_plus2", 64'(prog_addr), 64'(8'h00));

      // ---- PC wrap: BEQ at 0xFF taken -> 0x01 ----
      fill_nop();
      rom[255] = 9'h040;
      launch();
      repeat (511) @(negedge CLK);          // cycle 512: EXEC at PC 0xFF
      chk("beq_ff_addr", 64'(prog_addr), 64'(8'hFF));
      alu_if.branch_en = 1'b1;
      @(negedge CLK);
      alu_if.branch_en = 1'b0;
      chk("wrap_ff_plus2", 64'(prog_addr), 64'(8'h01));

      // ---- carry chain: ADD, ADD, ASSIGN, ADD ----
      fill_nop();
      rom[0] = 9'h013; rom[1] = 9'h013; rom[2] = 9'h105; rom[3] = 9'h013;
      launch();
      @(negedge CLK);                       // cycle 2: EXEC ADD
      chk("carry_first", 64'(alu_if.sc_in), 64'(0));
      alu_if.alu_sc_out = 1'b1;
      @(negedge CLK);
      alu_if.alu_sc_out = 1'b0;
      @(negedge CLK);                       // cycle 4: EXEC second ADD
      chk("carry_second_add", 64'(alu_if.sc_in), 64'(CARRY_ON));
      alu_if.alu_sc_out = 1'b1;
      @(negedge CLK);
      alu_if.alu_sc_out = 1'b0;
      @(negedge CLK);                       // cycle 6: EXEC ASSIGN (no carry load)
      @(negedge CLK);
      @(negedge CLK);                       // cycle 8: EXEC last ADD
      chk("carry_kept_over_assign", 64'(alu_if.sc_in), 64'(CARRY_ON));

      // ---- random programs vs model ----
      run_random(300);
      run_random(300);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
